// File: rtl/aurora_link_pkg.sv
// rtl/aurora_link_pkg.sv - shared constants and state encoding for the Aurora link sequencer
package aurora_link_pkg;
  localparam int CNT_W   = 24;
  localparam int RETRY_W = 8;

  typedef enum logic [2:0] {
    ST_RESET_GT      = 3'd0,
    ST_WAIT_LOCK     = 3'd1,
    ST_RESET_AURORA  = 3'd2,
    ST_WAIT_CHANNEL  = 3'd3,
    ST_LINK_UP       = 3'd4,
    ST_FAILED        = 3'd5
  } link_state_e;
endpackage

// File: rtl/aurora_link_sync.sv
// rtl/aurora_link_sync.sv - N-bit two-flop synchronizer with per-bit reset value
module aurora_link_sync
  import aurora_link_pkg::*;
#(
  parameter int             N       = 1,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/aurora_link_sequencer.sv
// rtl/aurora_link_sequencer.sv - GT/Aurora reset ordering, lock/channel wait and retry control
module aurora_link_sequencer
  import aurora_link_pkg::*;
#(
  parameter int GT_RESET_CYCLES     = 128,
  parameter int AURORA_RESET_CYCLES = 64,
  parameter int LOCK_TIMEOUT        = 1048576,
  parameter int CHANNEL_TIMEOUT     = 4194304,
  parameter int UP_STABLE_CYCLES    = 16,
  parameter int MAX_RETRIES         = 8
) (
  input  logic               INIT_CLK,
  input  logic               RESET,
  input  logic               PLL_NOT_LOCKED,
  input  logic               CHANNEL_UP,
  input  logic               HARD_ERR,
  input  logic               REARM,
  output logic               GT_RESET,
  output logic               AURORA_RESET,
  output logic               LINK_READY,
  output logic               LINK_FAIL,
  output logic [2:0]         STATE,
  output logic [RETRY_W-1:0] RETRY_COUNT
);

  // The cycle counter is zero on the first cycle of a state, so "N cycles" ends at N-1.
  localparam logic [CNT_W-1:0]   GT_LAST   = CNT_W'(GT_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   AR_LAST   = CNT_W'(AURORA_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CHAN_LAST = CNT_W'(CHANNEL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   UP_NEED   = CNT_W'(UP_STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  logic [2:0] sync_s;
  logic       lock_lost_s, chan_s, herr_s;

  aurora_link_sync #(
    .N       (3),
    .RST_VAL (3'b001)
  ) u_sync (
    .clk (INIT_CLK),
    .rst (RESET),
    .d   ({HARD_ERR, CHANNEL_UP, PLL_NOT_LOCKED}),
    .q   (sync_s)
  );

  assign lock_lost_s = sync_s[0];
  assign chan_s      = sync_s[1];
  assign herr_s      = sync_s[2];

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stab_q, stab_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               gt_reset_q, gt_reset_d;
  logic               aurora_reset_q, aurora_reset_d;
  logic               link_ready_q, link_ready_d;
  logic               link_fail_q, link_fail_d;
  logic [RETRY_W-1:0] retry_inc;
  logic [2:0]         fail_state;
  logic               fail;

  always_comb begin
    retry_inc  = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
    fail_state = (MAX_RETRIES != 0 && 32'(retry_inc) >= MAX_RETRIES) ? ST_FAILED : ST_RESET_GT;
    fail       = 1'b0;
    state_d    = state_q;
    retry_d    = retry_q;

    // Fail conditions are tested first so they win over any success edge in the same cycle.
    case (state_q)
      ST_RESET_GT: begin
        if (cnt_q == GT_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (cnt_q == LOCK_LAST)  fail = 1'b1;
        else if (!lock_lost_s)   state_d = ST_RESET_AURORA;
      end
      ST_RESET_AURORA: begin
        if (lock_lost_s)         fail = 1'b1;
        else if (cnt_q == AR_LAST) state_d = ST_WAIT_CHANNEL;
      end
      ST_WAIT_CHANNEL: begin
        if (cnt_q == CHAN_LAST || lock_lost_s || herr_s) begin
          fail = 1'b1;
        end else if (stab_q >= UP_NEED) begin
          state_d = ST_LINK_UP;
          retry_d = '0;
        end
      end
      ST_LINK_UP: begin
        if (!chan_s || herr_s || lock_lost_s) fail = 1'b1;
      end
      ST_FAILED: begin
        if (REARM) begin
          state_d = ST_RESET_GT;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET_GT;
    endcase

    if (fail) begin
      state_d = fail_state;
      retry_d = retry_inc;
    end

    cnt_d  = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    stab_d = !chan_s ? '0 : ((stab_q == '1) ? stab_q : stab_q + 1'b1);

    gt_reset_d     = (state_d == ST_RESET_GT) || (state_d == ST_FAILED);
    aurora_reset_d = (state_d == ST_RESET_GT) || (state_d == ST_WAIT_LOCK) ||
                     (state_d == ST_RESET_AURORA) || (state_d == ST_FAILED);
    link_ready_d   = (state_d == ST_LINK_UP);
    link_fail_d    = (state_d == ST_FAILED);
  end

  always_ff @(posedge INIT_CLK) begin
    if (RESET) begin
      state_q        <= ST_RESET_GT;
      cnt_q          <= '0;
      stab_q         <= '0;
      retry_q        <= '0;
      gt_reset_q     <= 1'b1;
      aurora_reset_q <= 1'b1;
      link_ready_q   <= 1'b0;
      link_fail_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stab_q         <= stab_d;
      retry_q        <= retry_d;
      gt_reset_q     <= gt_reset_d;
      aurora_reset_q <= aurora_reset_d;
      link_ready_q   <= link_ready_d;
      link_fail_q    <= link_fail_d;
    end
  end

  assign GT_RESET     = gt_reset_q;
  assign AURORA_RESET = aurora_reset_q;
  assign LINK_READY   = link_ready_q;
  assign LINK_FAIL    = link_fail_q;
  assign STATE        = state_q;
  assign RETRY_COUNT  = retry_q;

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// tb/tb_aurora_link_sequencer.sv - scoreboard bench for the Aurora link sequencer
module tb_aurora_link_sequencer;

  localparam logic [2:0] E_RG = 3'd0, E_WL = 3'd1, E_RA = 3'd2, E_WC = 3'd3, E_LU = 3'd4, E_FA = 3'd5;

  localparam int GA = 128, ARA = 64, LTA = 1000, CTA = 3000, USA = 16, MRA = 3;
  localparam int GB = 8,   ARB = 4,  LTB = 24,   CTB = 40,   USB = 4,  MRB = 0;

  typedef struct {
    int         t;
    logic [2:0] st;
    logic [7:0] rc;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   checks = 0, failures = 0;
  bit   mon_a = 0, mon_b = 0, done_a = 0, done_b = 0;
  evt_t qa[$], qb[$];

  logic rst_a, pll_a, chan_a, herr_a, rearm_a;
  logic gt_a, ar_a, lr_a, lf_a;
  logic [2:0] st_a;
  logic [7:0] rc_a;
  logic rst_b, pll_b, chan_b, herr_b, rearm_b;
  logic gt_b, ar_b, lr_b, lf_b;
  logic [2:0] st_b;
  logic [7:0] rc_b;

  aurora_link_sequencer #(
    .GT_RESET_CYCLES(GA), .AURORA_RESET_CYCLES(ARA), .LOCK_TIMEOUT(LTA),
    .CHANNEL_TIMEOUT(CTA), .UP_STABLE_CYCLES(USA), .MAX_RETRIES(MRA)
  ) dut_a (
    .INIT_CLK(clk), .RESET(rst_a), .PLL_NOT_LOCKED(pll_a), .CHANNEL_UP(chan_a),
    .HARD_ERR(herr_a), .REARM(rearm_a), .GT_RESET(gt_a), .AURORA_RESET(ar_a),
    .LINK_READY(lr_a), .LINK_FAIL(lf_a), .STATE(st_a), .RETRY_COUNT(rc_a)
  );

  aurora_link_sequencer #(
    .GT_RESET_CYCLES(GB), .AURORA_RESET_CYCLES(ARB), .LOCK_TIMEOUT(LTB),
    .CHANNEL_TIMEOUT(CTB), .UP_STABLE_CYCLES(USB), .MAX_RETRIES(MRB)
  ) dut_b (
    .INIT_CLK(clk), .RESET(rst_b), .PLL_NOT_LOCKED(pll_b), .CHANNEL_UP(chan_b),
    .HARD_ERR(herr_b), .REARM(rearm_b), .GT_RESET(gt_b), .AURORA_RESET(ar_b),
    .LINK_READY(lr_b), .LINK_FAIL(lf_b), .STATE(st_b), .RETRY_COUNT(rc_b)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // {GT_RESET, AURORA_RESET, LINK_READY, LINK_FAIL} implied by a state.
  function automatic logic [3:0] exp_outs(input logic [2:0] st);
    case (st)
      E_RG:    return 4'b1100;
      E_WL:    return 4'b0100;
      E_RA:    return 4'b0100;
      E_WC:    return 4'b0000;
      E_LU:    return 4'b0010;
      default: return 4'b1101;
    endcase
  endfunction

  task automatic pa(input int t, input logic [2:0] st, input logic [7:0] rc);
    qa.push_back('{t, st, rc});
  endtask

  task automatic pb(input int t, input logic [2:0] st, input logic [7:0] rc);
    qb.push_back('{t, st, rc});
  endtask

  task automatic at_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic check_evt(input string tag, input bit have, input evt_t e, input logic [2:0] st,
                           input logic [7:0] rc, input logic [3:0] outs);
    logic [3:0] eo;
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected got state=%0d rc=%0d at cycle %0d expected no event", tag, st, rc, cyc);
      return;
    end
    eo = exp_outs(e.st);
    chk($sformatf("%s_time", tag), cyc, e.t);
    chk($sformatf("%s_state", tag), int'(st), int'(e.st));
    chk($sformatf("%s_retry", tag), int'(rc), int'(e.rc));
    chk($sformatf("%s_outs", tag), int'(outs), int'(eo));
  endtask

  task automatic reset_chk(input string tag, input logic [2:0] st, input logic [7:0] rc,
                           input logic gt, input logic ar, input logic lr, input logic lf);
    chk($sformatf("%s_rst_state", tag), int'(st), 0);
    chk($sformatf("%s_rst_retry", tag), int'(rc), 0);
    chk($sformatf("%s_rst_gt", tag), int'(gt), 1);
    chk($sformatf("%s_rst_ar", tag), int'(ar), 1);
    chk($sformatf("%s_rst_ready", tag), int'(lr), 0);
    chk($sformatf("%s_rst_fail", tag), int'(lf), 0);
  endtask

  logic [10:0] prev_a, prev_b;
  evt_t        ea, eb;
  bit          ha, hb;

  always @(posedge clk) begin
    #1;
    if (mon_a && ({st_a, rc_a} != prev_a)) begin
      ha = (qa.size() > 0);
      if (ha) ea = qa.pop_front();
      check_evt("a", ha, ea, st_a, rc_a, {gt_a, ar_a, lr_a, lf_a});
    end
    prev_a = {st_a, rc_a};
  end

  always @(posedge clk) begin
    #1;
    if (mon_b && ({st_b, rc_b} != prev_b)) begin
      hb = (qb.size() > 0);
      if (hb) eb = qb.pop_front();
      check_evt("b", hb, eb, st_b, rc_b, {gt_b, ar_b, lr_b, lf_b});
    end
    prev_b = {st_b, rc_b};
  end

  // Instance A: bring-up, glitch, link drops, coincident events, mid reset, lock timeouts, rearm.
  initial begin
    int r, w, p, a, c, u1, u2, l, h, f, d, x, q;
    rst_a = 1; pll_a = 1; chan_a = 0; herr_a = 0; rearm_a = 0;
    at_edge(2);
    reset_chk("a", st_a, rc_a, gt_a, ar_a, lr_a, lf_a);
    mon_a = 1;
    at_edge(3);
    rst_a = 0;
    r = 3;

    w = r + GA;                        pa(w, E_WL, 0);
    p = r + int'($urandom_range(40, GA + 200));
    a = imax(w + 1, p + 3);            pa(a, E_RA, 0);
    c = a + ARA;                       pa(c, E_WC, 0);
    at_edge(p); pll_a = 0;

    u1 = c + int'($urandom_range(5, 30));
    at_edge(u1); chan_a = 1;
    at_edge(u1 + 10); chan_a = 0;
    u2 = u1 + 10 + int'($urandom_range(5, 40));
    l = u2 + 3 + USA;                  pa(l, E_LU, 0);
    at_edge(u2); chan_a = 1;

    h = l + int'($urandom_range(5, 50));
    f = h + 3;                         pa(f, E_RG, 1);
    w = f + GA;                        pa(w, E_WL, 1);
    a = w + 1;                         pa(a, E_RA, 1);
    c = a + ARA;                       pa(c, E_WC, 1);
    l = c + 1;                         pa(l, E_LU, 0);
    at_edge(h); herr_a = 1;
    at_edge(h + 1); herr_a = 0;

    d = l + int'($urandom_range(5, 40));
    f = d + 3;                         pa(f, E_RG, 1);
    w = f + GA;                        pa(w, E_WL, 1);
    a = w + 1;                         pa(a, E_RA, 1);
    c = a + ARA;                       pa(c, E_WC, 1);
    at_edge(d); chan_a = 0;

    u1 = c + int'($urandom_range(3, 20));
    f = u1 + 3 + USA;                  pa(f, E_RG, 2);
    w = f + GA;                        pa(w, E_WL, 2);
    a = w + 1;                         pa(a, E_RA, 2);
    c = a + ARA;                       pa(c, E_WC, 2);
    at_edge(u1); chan_a = 1;
    at_edge(u1 + USA); herr_a = 1;
    at_edge(u1 + USA + 1); herr_a = 0;
    at_edge(f); chan_a = 0;

    x = c + int'($urandom_range(3, 50));
    pa(x + 1, E_RG, 0);
    r = x + 1;
    for (int i = 0; i < 3; i++) begin
      w = r + GA;                      pa(w, E_WL, 8'(i));
      r = w + LTA;                     pa(r, (i == 2) ? E_FA : E_RG, 8'(i + 1));
    end
    at_edge(x); rst_a = 1; pll_a = 1;
    at_edge(x + 1); rst_a = 0;

    q = r + int'($urandom_range(20, 60));
    pa(q + 1, E_RG, 0);
    pa(q + 1 + GA, E_WL, 0);
    at_edge(r + 5); herr_a = 1; chan_a = 1; pll_a = 0;
    at_edge(r + 8); herr_a = 0; chan_a = 0; pll_a = 1;
    at_edge(q); rearm_a = 1;
    at_edge(q + 1); rearm_a = 0;
    at_edge(q + 1 + GA + 10);
    mon_a = 0;
    done_a = 1;
  end

  // Instance B: channel timeout, then endless lock timeouts with unlimited retries.
  initial begin
    int r, w, p, a, c, f;
    rst_b = 1; pll_b = 1; chan_b = 0; herr_b = 0; rearm_b = 0;
    at_edge(2);
    reset_chk("b", st_b, rc_b, gt_b, ar_b, lr_b, lf_b);
    mon_b = 1;
    at_edge(3);
    rst_b = 0;
    r = 3;

    w = r + GB;                        pb(w, E_WL, 0);
    p = r + int'($urandom_range(1, 20));
    a = imax(w + 1, p + 3);            pb(a, E_RA, 0);
    c = a + ARB;                       pb(c, E_WC, 0);
    f = c + CTB;                       pb(f, E_RG, 1);
    r = f;
    for (int n = 1; n <= 260; n++) begin
      w = r + GB;                      pb(w, E_WL, 8'(sat255(n)));
      r = w + LTB;                     pb(r, E_RG, 8'(sat255(n + 1)));
    end
    at_edge(p); pll_b = 0;
    at_edge(f); pll_b = 1;
    at_edge(r + 5);
    mon_b = 0;
    done_b = 1;
  end

  initial begin
    int lim;
    lim = 0;
    while (!(done_a && done_b) && lim < 20000) begin
      @(negedge clk);
      lim++;
    end
    chk("run_complete", int'(done_a && done_b), 1);
    chk("a_pending_events", qa.size(), 0);
    chk("b_pending_events", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aurora_link_sequencer.md
# aurora_link_sequencer

Reset and bring-up sequencer for the single-lane Aurora 8b/10b link. It drives the GT and Aurora core resets in the required order and waits for the reference PLL to lock. It then waits for a stable channel-up, and on timeout, hard error or link drop it retries the whole sequence. It sits beside the Aurora clock module, consumes its PLL_NOT_LOCKED output and the core's status, and presents a single LINK_READY to user logic.

## Interface
Parameters:
- GT_RESET_CYCLES, 128: cycles GT_RESET is held in RESET_GT (≥1).
- AURORA_RESET_CYCLES, 64: extra cycles AURORA_RESET is held after lock (≥1).
- LOCK_TIMEOUT, 1048576: max cycles in WAIT_LOCK.
- CHANNEL_TIMEOUT, 4194304: max cycles in WAIT_CHANNEL.
- UP_STABLE_CYCLES, 16: consecutive synchronized CHANNEL_UP cycles required before LINK_UP (≥1).
- MAX_RETRIES, 8: consecutive failed attempts before FAILED; 0 = retry forever.

Ports:
- INIT_CLK  in  1  free-running init clock; only clock of the block.
- RESET  in  1  synchronous, active-high reset.
- PLL_NOT_LOCKED  in  1  from the clock module; asynchronous to INIT_CLK.
- CHANNEL_UP  in  1  Aurora channel up; asynchronous.
- HARD_ERR  in  1  Aurora hard error; asynchronous.
- REARM  in  1  INIT_CLK-synchronous pulse; leaves FAILED.
- GT_RESET  out  1  GT/transceiver reset.
- AURORA_RESET  out  1  Aurora core reset.
- LINK_READY  out  1  high only in LINK_UP.
- LINK_FAIL  out  1  high only in FAILED.
- STATE  out  3  current state encoding.
- RETRY_COUNT  out  8  consecutive failed attempts, saturating at 255.

## Operation
- PLL_NOT_LOCKED, CHANNEL_UP and HARD_ERR each pass through a 2-flop synchronizer; the FSM sees only the synchronized _s versions. Synchronizer reset values: lock_lost_s=1, chan_s=0, herr_s=0.
- There is one shared 24-bit cycle counter, cleared on every state entry and incremented every cycle otherwise. A separate stability counter counts consecutive chan_s=1 cycles and clears whenever chan_s=0.
- States, with STATE encoding:
  - RESET_GT (0): GT_RESET=1, AURORA_RESET=1. After GT_RESET_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK (1): GT_RESET=0, AURORA_RESET=1. lock_lost_s=0 → RESET_AURORA. Counter reaches LOCK_TIMEOUT → fail.
  - RESET_AURORA (2): AURORA_RESET=1. After AURORA_RESET_CYCLES cycles, go to WAIT_CHANNEL. lock_lost_s=1 → fail.
  - WAIT_CHANNEL (3): both resets 0. Stability counter reaches UP_STABLE_CYCLES → LINK_UP. Counter reaches CHANNEL_TIMEOUT, or lock_lost_s=1, or herr_s=1 → fail.
  - LINK_UP (4): LINK_READY=1. Entry clears RETRY_COUNT. chan_s=0, herr_s=1 or lock_lost_s=1 → fail.
  - FAILED (5): GT_RESET=1, AURORA_RESET=1, LINK_FAIL=1. REARM → RESET_GT and clears RETRY_COUNT. All other inputs are ignored.
- Fail action, taken in one cycle:
  - RETRY_COUNT increments, saturating at 255.
  - If MAX_RETRIES≠0 and the incremented value ≥ MAX_RETRIES, go to FAILED; otherwise go to RESET_GT.
- A link drop from LINK_UP counts as attempt 1, because RETRY_COUNT was cleared on entry to LINK_UP.
- Priority when events coincide in one cycle:
  - RESET beats everything.
  - The fail conditions beat a success transition, e.g. timeout and lock on the same cycle in WAIT_LOCK → fail.
  - In WAIT_CHANNEL, stability reached together with herr_s → fail.
- Codes 6 and 7 are illegal and go to RESET_GT without incrementing RETRY_COUNT.

## Timing
- All outputs are registered and decoded from the state register. No combinational input→output path.
- Reset values of every output:
  - GT_RESET=1, AURORA_RESET=1.
  - LINK_READY=0, LINK_FAIL=0.
  - STATE=0, RETRY_COUNT=0.
  - cycle counter and stability counter = 0.
- GT_RESET is high for exactly GT_RESET_CYCLES cycles after RESET falls. It falls on the first WAIT_LOCK cycle.
- Input-to-FSM latency is 2 cycles through the synchronizer; the FSM reacts on the next edge.
- LINK_READY rises UP_STABLE_CYCLES+3 cycles, ±1, after the raw CHANNEL_UP rises in WAIT_CHANNEL. It falls 3 cycles after the raw CHANNEL_UP falls.
- RESET asserted mid-sequence (any state) returns the block to RESET_GT with reset values on the next edge.

## Structure
- aurora_link_pkg holds:
  - the state enum, with the encodings above;
  - the counter width constant CNT_W=24;
  - the RETRY_W=8 constant.
- Sub-module aurora_link_sync: a parameterizable N-bit 2-flop synchronizer with per-bit reset value. It is instantiated once for the 3 status inputs.
- FSM and counters live in the top module.

## Test plan
- Clean bring-up:
  - release RESET; drop PLL_NOT_LOCKED at cycle 200; raise CHANNEL_UP at cycle 500;
  - → GT_RESET falls at cycle 128;
  - → AURORA_RESET falls 64 cycles after the synchronized lock;
  - → LINK_READY=1 about 19 cycles after CHANNEL_UP; RETRY_COUNT=0.
- Lock timeout (LOCK_TIMEOUT=1000, PLL_NOT_LOCKED held high):
  - → returns to RESET_GT every 1128 cycles; RETRY_COUNT=1,2,…;
  - → with MAX_RETRIES=3, STATE=5 and LINK_FAIL=1 after the third timeout;
  - → REARM → STATE=0, RETRY_COUNT=0.
- CHANNEL_UP glitch:
  - in WAIT_CHANNEL, pulse CHANNEL_UP high for 10 cycles, then low;
  - → no LINK_UP; stability counter clears.
  - A later 20-cycle-stable CHANNEL_UP → LINK_UP.
- Link drop:
  - in LINK_UP, assert HARD_ERR for 1 cycle;
  - → LINK_READY falls within 3 cycles, STATE=0, RETRY_COUNT=1, GT_RESET=1.
- Simultaneous events:
  - in WAIT_CHANNEL, CHANNEL_UP becomes stable on the same cycle HARD_ERR is seen;
  - → fail path taken, STATE=0, not 4.
- Mid-operation reset and saturation:
  - RESET in WAIT_CHANNEL → all outputs at reset values next cycle;
  - with MAX_RETRIES=0 and forced timeouts, RETRY_COUNT saturates at 255 and never reaches FAILED.
